// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, WAIT_STATES wait cycles, registered response.
// Define DMEM_MISALIGN_ERR_EN to fault misaligned half/word accesses instead of masking the low address bits.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int DEPTH   = 2 ** ADDR_WIDTH;
  localparam int WS_M1   = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam bit NO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        we_q, we_d, uns_q, uns_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;

  logic [31:0] mem [DEPTH];

  logic                  acc_we, acc_uns, fault, enter_resp, mem_we;
  logic [31:0]           acc_addr, acc_wdata, rd_word, load_data, wr_data;
  logic [1:0]            acc_size, lane;
  logic [3:0]            be;
  logic [ADDR_WIDTH-1:0] widx;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
`ifdef DMEM_MISALIGN_ERR_EN
  logic                  misalign;
`endif

  // With no wait states the access executes on the accept edge, so it reads the live request.
  always_comb begin
    acc_we    = (state_q == IDLE) ? req_we       : we_q;
    acc_uns   = (state_q == IDLE) ? req_unsigned : uns_q;
    acc_addr  = (state_q == IDLE) ? req_addr     : addr_q;
    acc_wdata = (state_q == IDLE) ? req_wdata    : wdata_q;
    acc_size  = (state_q == IDLE) ? req_size     : size_q;
  end

  always_comb begin
    lane = acc_addr[1:0];
    if (acc_size == 2'b01) lane[0] = 1'b0;
    if (acc_size == 2'b10) lane    = 2'b00;
    widx = acc_addr[ADDR_WIDTH+1:2];
`ifdef DMEM_MISALIGN_ERR_EN
    misalign = ((acc_size == 2'b01) && acc_addr[0]) ||
               ((acc_size == 2'b10) && (acc_addr[1:0] != 2'b00));
    fault = (acc_size == 2'b11) || (|acc_addr[31:ADDR_WIDTH+2]) || misalign;
`else
    fault = (acc_size == 2'b11) || (|acc_addr[31:ADDR_WIDTH+2]);
`endif
  end

  always_comb begin
    rd_word = mem[widx];
    rd_byte = rd_word[{lane, 3'b000} +: 8];
    rd_half = rd_word[{lane[1], 4'b0000} +: 16];
    case (acc_size)
      2'b00:   load_data = acc_uns ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_data = acc_uns ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_data = rd_word;
    endcase
    case (acc_size)
      2'b00: begin
        be      = 4'b0001 << lane;
        wr_data = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        be      = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{acc_wdata[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        wr_data = acc_wdata;
      end
    endcase
  end

  // Gating with rst_n keeps a store from committing while reset is asserted.
  assign enter_resp = ((state_q == IDLE) && req_valid && NO_WAIT) ||
                      ((state_q == WAIT) && (cnt_q == 3'd0));
  assign mem_we     = enter_resp && acc_we && !fault && rst_n;

  always_ff @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i +: 8] <= wr_data[8*i +: 8];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    we_d        = we_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d        = req_we;
        uns_d       = req_unsigned;
        addr_d      = req_addr;
        wdata_d     = req_wdata;
        size_d      = req_size;
        cnt_d       = 3'(WS_M1);
        req_ready_d = 1'b0;
        state_d     = NO_WAIT ? RESP : WAIT;
      end
      WAIT: if (cnt_q == 3'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 3'd1;
      RESP: if (rsp_ready) begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = fault;
      rsp_rdata_d = (fault || acc_we) ? 32'd0 : load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      size_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the far end of the memory-access stage's load/store port. It accepts one request at a time over a valid/ready handshake and models a configurable number of wait states. It performs byte, half and word accesses on a word-organised RAM and returns sign- or zero-extended load data, or a store acknowledge, over a second valid/ready channel. It replaces the combinational array inside the memory-access stage so that stage can be tested against realistic memory latency.

## Interface
- ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH words (default 4 KiB).
- WAIT_STATES, 1, extra cycles between accept and response; legal range 0..7.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (REG_B); the low bits are used for sub-word stores.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is an error.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access faulted; no memory side effect.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid: latch all req_* fields. Go to WAIT if WAIT_STATES>0; otherwise go to RESP.
- WAIT: a 3-bit counter loads WAIT_STATES-1 at accept and decrements each cycle. At 0, go to RESP.
- Entry to RESP: on this edge the memory access executes, rsp_* are registered, and rsp_valid rises.
- RESP: hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready. Then go to IDLE.
- req_ready=0 in WAIT and RESP. req_* changes there are ignored.
- Fault (rsp_err=1) is raised for any of:
  - req_size=11;
  - address above the RAM: req_addr[31:ADDR_WIDTH+2] ≠ 0;
  - misaligned access (see Configuration).
- On a fault: no write occurs and rsp_rdata=0.
- Store lanes:
  - byte writes wdata[7:0] to lane addr[1:0];
  - half writes wdata[15:0] to lanes {addr[1],0}..{addr[1],1};
  - word writes all 4 lanes.
  - Other lanes are untouched.
- Load: select the lane(s) by addr[1:0]. Extend from bit 7 or bit 15 per req_unsigned. Word loads are passed through unchanged.
- RAM contents are not reset; power-up contents are undefined.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE, wait counter=0.
- Latency: rsp_valid rises exactly WAIT_STATES+1 cycles after the accept edge.
- Minimum transaction period: WAIT_STATES+2 cycles.
- req_ready reasserts in the cycle after the rsp handshake edge.
- No request is accepted on the same edge as a response handshake.
- A store commits on the RESP-entry edge. A load issued afterwards sees the new data.
- Reset mid-transaction:
  - immediate return to IDLE with reset output values;
  - a store not yet committed is dropped;
  - a pending response is discarded.
- rsp_ready held high: RESP lasts exactly 1 cycle.

## Configuration
- DMEM_MISALIGN_ERR_EN defined:
  - half at odd address → fault;
  - word with addr[1:0]≠0 → fault.
- DMEM_MISALIGN_ERR_EN undefined:
  - alignment bits are masked: half uses addr[0]=0, word uses addr[1:0]=00;
  - access proceeds normally and misalignment never sets rsp_err;
  - size and range faults remain.

## Test plan
- Reset, idle checks:
  - assert rst_n low mid-WAIT of a store to 0x4 → outputs at reset values; a later load of 0x4 does not return the dropped data (preload 0x4 = 0).
- Word round trip with WAIT_STATES=1:
  - store 0xABCD1234 to 0x4 → rsp_valid 2 cycles after accept, rdata=0, err=0;
  - load 0x4 → rdata=0xABCD1234.
- Sub-word stores and extension:
  - word 0x87654321 stored at 0x8, then byte 0xFF stored at 0x9;
  - signed byte load 0x9 → 0xFFFFFFFF; unsigned → 0x000000FF;
  - signed half load 0xA → 0xFFFF8765; word load 0x8 → 0x8765FF21.
- Backpressure:
  - hold rsp_ready=0 for 5 cycles → rsp_valid and rdata stable and req_ready=0 throughout;
  - release → req_ready=1 on the next cycle.
- Faults:
  - size=11 → err=1, rdata=0, no write;
  - address 0x1000 (ADDR_WIDTH=10) → err=1;
  - word store at 0x6 → with macro: err=1 and 0x4 unchanged; without macro: data written to 0x4, err=0.
- Latency sweep:
  - WAIT_STATES=0 and 7, back-to-back loads with rsp_ready=1 → response 1 and 8 cycles after accept; period 2 and 9 cycles.
